lsu_mem_req: RTL and testbench

- Load/store request side of the five-stage core's memory stage; the producer for the WriteBack stage.
- Accepts one execute-stage op at a time and issues a word-aligned request to data memory with a req/gnt handshake.
- For stores, replicates store data and generates the write strobe. For loads, waits for read data and presents it with a read strobe and sign flag, so WriteBack can extract and extend the loaded value.
- Non-memory results pass through with one register stage.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_store_align.sv | 37 +++
 rtl/lsu_mem_req.sv | 170 +++++++++++++++++
 tb/tb_lsu_mem_req.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store request unit of the memory stage.
package lsu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned BYTES = XLEN / 8;
    localparam int unsigned RD_W  = 5;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } state_e;

    localparam logic [BYTES-1:0] STRB_NONE = 4'b0000;
    localparam logic [BYTES-1:0] STRB_B    = 4'b0001;
    localparam logic [BYTES-1:0] STRB_H    = 4'b0011;
    localparam logic [BYTES-1:0] STRB_W    = 4'b1111;

    // Writeback context captured at accept and replayed when load data returns.
    typedef struct packed {
        logic [RD_W-1:0]  rd;
        logic             rd_wen;
        logic             lsign;
        logic [BYTES-1:0] rstrb;
        logic             load;
    } ld_ctx_t;

endpackage

// File: rtl/lsu_store_align.sv
// Byte-lane alignment shared by stores and loads: replicated write data,
// write/read strobes and the misalignment flag for a given size and offset.
module lsu_store_align
    import lsu_pkg::*;
(
    input  logic [1:0]       addr_lo,
    input  logic [1:0]       size,
    input  logic [XLEN-1:0]  rs2,
    output logic [XLEN-1:0]  wdata_c,
    output logic [BYTES-1:0] wstrb_c,
    output logic [BYTES-1:0] rstrb_c,
    output logic             misalign_c
);

    // Encodings other than byte/half behave as a word access.
    always_comb begin
        wdata_c    = rs2;
        wstrb_c    = STRB_W;
        misalign_c = 1'b0;
        case (size)
            SZ_B: begin
                wdata_c = {4{rs2[7:0]}};
                wstrb_c = STRB_B << addr_lo;
            end
            SZ_H: begin
                wdata_c    = {2{rs2[15:0]}};
                wstrb_c    = STRB_H << addr_lo;
                misalign_c = addr_lo[0];
            end
            default: begin
                misalign_c = |addr_lo;
            end
        endcase
        rstrb_c = wstrb_c;
    end

endmodule

// File: rtl/lsu_mem_req.sv
// Memory-stage load/store request unit: issues word-aligned data-memory requests
// over req/gnt, collects load data, and forwards ALU results to WriteBack.
module lsu_mem_req
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              ex_vld,
    output logic              ex_ready,
    input  logic [XLEN-1:0]   ex_alu_out,
    input  logic              ex_load,
    input  logic              ex_store,
    input  logic [1:0]        ex_size,
    input  logic              ex_lsign,
    input  logic [XLEN-1:0]   ex_rs2_data,
    input  logic [RD_W-1:0]   ex_rd,
    input  logic              ex_rd_wen,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [BYTES-1:0]  mem_wstrb,
    input  logic              mem_gnt,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_rvld,
    output logic [XLEN-1:0]   lsu_out,
    output logic              lsu_out_vld,
    output logic [XLEN-1:0]   lsu_mem_rdata,
    output logic              lsu_mem_rvld,
    output logic [BYTES-1:0]  lsu_rstrb,
    output logic [RD_W-1:0]   lsu_rd,
    output logic              lsu_rd_wen,
    output logic              lsu_lsign,
    output logic              lsu_misalign
);

    state_e           state_q;
    state_e           state_d;
    ld_ctx_t          ctx_q;

    logic [XLEN-1:0]  al_wdata;
    logic [BYTES-1:0] al_wstrb;
    logic [BYTES-1:0] al_rstrb;
    logic             al_misalign;

    logic             accept;
    logic             alu_fire;
    logic             mis_fire;
    logic             mem_fire;
    logic             ld_done;

    lsu_store_align u_align (
        .addr_lo    (ex_alu_out[1:0]),
        .size       (ex_size),
        .rs2        (ex_rs2_data),
        .wdata_c    (al_wdata),
        .wstrb_c    (al_wstrb),
        .rstrb_c    (al_rstrb),
        .misalign_c (al_misalign)
    );

    // ex_ready is a registered copy of "FSM is IDLE", so it gates acceptance directly.
    assign accept = ex_vld & ex_ready;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        alu_fire = 1'b0;
        mis_fire = 1'b0;
        mem_fire = 1'b0;
        ld_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!(ex_load | ex_store)) begin
                        alu_fire = 1'b1;
                    end else if (al_misalign) begin
                        mis_fire = 1'b1;
                    end else begin
                        mem_fire = 1'b1;
                        state_d  = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_d = ctx_q.load ? WAIT_R : IDLE;
                end
            end
            WAIT_R: begin
                if (mem_rvld) begin
                    ld_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and pulse outputs.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ex_ready     <= 1'b0;
            mem_req      <= 1'b0;
            lsu_out_vld  <= 1'b0;
            lsu_mem_rvld <= 1'b0;
            lsu_misalign <= 1'b0;
            lsu_rd_wen   <= 1'b0;
        end else begin
            ex_ready     <= (state_d == IDLE);
            mem_req      <= (state_d == REQ);
            lsu_out_vld  <= alu_fire;
            lsu_mem_rvld <= ld_done;
            lsu_misalign <= mis_fire;
            lsu_rd_wen   <= alu_fire ? ex_rd_wen : (ld_done ? ctx_q.rd_wen : 1'b0);
        end
    end

    // Request fields stay stable from accept through grant.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= STRB_NONE;
            ctx_q     <= '0;
        end else if (mem_fire) begin
            mem_we    <= ex_store;
            mem_addr  <= {ex_alu_out[ADDR_W-1:2], 2'b00};
            mem_wdata <= al_wdata;
            mem_wstrb <= ex_store ? al_wstrb : STRB_NONE;
            ctx_q     <= '{rd:     ex_rd,
                           rd_wen: ex_rd_wen,
                           lsign:  ex_lsign & ((ex_size == SZ_B) | (ex_size == SZ_H)),
                           rstrb:  al_rstrb,
                           load:   ex_load};
        end
    end

    // WriteBack payload; fields hold between valid pulses.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            lsu_out       <= '0;
            lsu_mem_rdata <= '0;
            lsu_rd        <= '0;
            lsu_rstrb     <= STRB_NONE;
            lsu_lsign     <= 1'b0;
        end else if (alu_fire) begin
            lsu_out <= ex_alu_out;
            lsu_rd  <= ex_rd;
        end else if (ld_done) begin
            lsu_mem_rdata <= mem_rdata;
            lsu_rd        <= ctx_q.rd;
            lsu_rstrb     <= ctx_q.rstrb;
            lsu_lsign     <= ctx_q.lsign;
        end
    end

endmodule

// File: tb/tb_lsu_mem_req.sv
// Scoreboard bench for lsu_mem_req: directed ops push expected responses,
// a negedge monitor pops and compares whenever the DUT presents an output.
module tb_lsu_mem_req;
    import lsu_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int K_ALU = 0;
    localparam int K_LD  = 1;
    localparam int K_MIS = 2;

    logic              CLK = 1'b0;
    logic              RSTN = 1'b0;
    logic              ex_vld = 1'b0;
    logic              ex_ready;
    logic [31:0]       ex_alu_out = '0;
    logic              ex_load = 1'b0;
    logic              ex_store = 1'b0;
    logic [1:0]        ex_size = '0;
    logic              ex_lsign = 1'b0;
    logic [31:0]       ex_rs2_data = '0;
    logic [4:0]        ex_rd = '0;
    logic              ex_rd_wen = 1'b0;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_gnt = 1'b0;
    logic [31:0]       mem_rdata = '0;
    logic              mem_rvld = 1'b0;
    logic [31:0]       lsu_out;
    logic              lsu_out_vld;
    logic [31:0]       lsu_mem_rdata;
    logic              lsu_mem_rvld;
    logic [3:0]        lsu_rstrb;
    logic [4:0]        lsu_rd;
    logic              lsu_rd_wen;
    logic              lsu_lsign;
    logic              lsu_misalign;

    typedef struct {
        int          kind;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        wen;
        logic [3:0]  rstrb;
        logic        lsign;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic        chk_wdata;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    exp_t exp_q[$];
    req_t req_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   req_cycles = 0;
    int   ld_seen = 0;
    int   acc_cyc = 0;

    always #5 CLK = ~CLK;

    lsu_mem_req #(.ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .ex_vld(ex_vld), .ex_ready(ex_ready), .ex_alu_out(ex_alu_out),
        .ex_load(ex_load), .ex_store(ex_store), .ex_size(ex_size),
        .ex_lsign(ex_lsign), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
        .ex_rd_wen(ex_rd_wen),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
        .mem_rdata(mem_rdata), .mem_rvld(mem_rvld),
        .lsu_out(lsu_out), .lsu_out_vld(lsu_out_vld),
        .lsu_mem_rdata(lsu_mem_rdata), .lsu_mem_rvld(lsu_mem_rvld),
        .lsu_rstrb(lsu_rstrb), .lsu_rd(lsu_rd), .lsu_rd_wen(lsu_rd_wen),
        .lsu_lsign(lsu_lsign), .lsu_misalign(lsu_misalign)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: pops expected writeback events and memory requests as they appear.
    always @(negedge CLK) begin
        exp_t e;
        req_t r;
        if (RSTN) begin
            check("both_vld", 32'(lsu_out_vld & lsu_mem_rvld), 32'h0);
            if (lsu_out_vld || lsu_mem_rvld || lsu_misalign) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got vld=%b rvld=%b mis=%b expected no output",
                             lsu_out_vld, lsu_mem_rvld, lsu_misalign);
                end else begin
                    e = exp_q.pop_front();
                    check("out_vld", 32'(lsu_out_vld), 32'(e.kind == K_ALU));
                    check("mem_rvld", 32'(lsu_mem_rvld), 32'(e.kind == K_LD));
                    check("misalign", 32'(lsu_misalign), 32'(e.kind == K_MIS));
                    if (e.kind == K_ALU) check("lsu_out", lsu_out, e.data);
                    if (e.kind == K_LD) begin
                        check("lsu_mem_rdata", lsu_mem_rdata, e.data);
                        check("lsu_rstrb", 32'(lsu_rstrb), 32'(e.rstrb));
                        check("lsu_lsign", 32'(lsu_lsign), 32'(e.lsign));
                    end
                    if (e.kind != K_MIS) begin
                        check("lsu_rd", 32'(lsu_rd), 32'(e.rd));
                        check("lsu_rd_wen", 32'(lsu_rd_wen), 32'(e.wen));
                    end else begin
                        check("mis_rd_wen", 32'(lsu_rd_wen), 32'h0);
                    end
                    if (e.cyc >= 0) check("latency", 32'(cyc), 32'(e.cyc));
                end
            end else begin
                check("rd_wen_idle", 32'(lsu_rd_wen), 32'h0);
            end
            if (mem_req) req_cycles++;
            if (mem_req && mem_gnt) begin
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got addr=0x%0h we=%b expected no request",
                             mem_addr, mem_we);
                end else begin
                    r = req_q.pop_front();
                    check("mem_addr", 32'(mem_addr), r.addr);
                    check("mem_we", 32'(mem_we), 32'(r.we));
                    check("mem_wstrb", 32'(mem_wstrb), 32'(r.wstrb));
                    if (r.chk_wdata) check("mem_wdata", mem_wdata, r.wdata);
                end
            end
            if (lsu_mem_rvld) ld_seen++;
        end
    end

    task automatic send(input logic [31:0] alu, input logic ld, input logic st,
                        input logic [1:0] size, input logic lsign, input logic [31:0] rs2,
                        input logic [4:0] rd, input logic wen);
        int n;
        ex_alu_out = alu; ex_load = ld; ex_store = st; ex_size = size;
        ex_lsign = lsign; ex_rs2_data = rs2; ex_rd = rd; ex_rd_wen = wen;
        ex_vld = 1'b1;
        n = 0;
        while (!ex_ready && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!ex_ready) check("ex_ready_timeout", 32'(ex_ready), 32'h1);
        @(posedge CLK); #1;
        acc_cyc = cyc;
        ex_vld = 1'b0;
    endtask

    task automatic mem_grant(input int w);
        int n;
        n = 0;
        while (!mem_req && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!mem_req) check("mem_req_timeout", 32'(mem_req), 32'h1);
        repeat (w) begin @(posedge CLK); #1; end
        mem_gnt = 1'b1;
        @(posedge CLK); #1;
        mem_gnt = 1'b0;
    endtask

    task automatic mem_return(input logic [31:0] d, input int dly);
        repeat (dly) begin @(posedge CLK); #1; end
        mem_rvld = 1'b1;
        mem_rdata = d;
        @(posedge CLK); #1;
        mem_rvld = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic rst_checks();
        check("rst_ctrl", 32'({ex_ready, mem_req, mem_we, lsu_out_vld, lsu_mem_rvld,
                               lsu_rd_wen, lsu_lsign, lsu_misalign}), 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_lanes", 32'({mem_wstrb, lsu_rstrb, lsu_rd}), 32'h0);
        check("rst_lsu_out", lsu_out, 32'h0);
        check("rst_rdata", lsu_mem_rdata, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0;
        int s;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        rst_checks();
        RSTN = 1'b1;
        @(posedge CLK); #1;
        check("ready_after_rst", 32'(ex_ready), 32'h1);

        // Back-to-back ALU ops
        send(32'h11, 1'b0, 1'b0, SZ_W, 1'b0, 32'h0, 5'd5, 1'b1);
        exp_q.push_back('{K_ALU, 32'h11, 5'd5, 1'b1, 4'h0, 1'b0, acc_cyc});
        a0 = acc_cyc;
        send(32'h22, 1'b0, 1'b0, SZ_W, 1'b0, 32'h0, 5'd6, 1'b1);
        exp_q.push_back('{K_ALU, 32'h22, 5'd6, 1'b1, 4'h0, 1'b0, acc_cyc});
        check("alu_back2back", 32'(acc_cyc - a0), 32'h1);

        // SB at 0x1003, grant after two wait cycles
        idle(1);
        req_q.push_back('{32'h1000, 1'b1, 1'b1, 32'hABABABAB, 4'b1000});
        req_cycles = 0;
        send(32'h1003, 1'b0, 1'b1, SZ_B, 1'b0, 32'h123456AB, 5'd0, 1'b0);
        mem_grant(2);
        idle(2);
        check("sb_req_cycles", 32'(req_cycles), 32'h3);
        check("sb_ready", 32'(ex_ready), 32'h1);

        // Signed LH at 0x2002
        req_q.push_back('{32'h2000, 1'b0, 1'b0, 32'h0, 4'b0000});
        send(32'h2002, 1'b1, 1'b0, SZ_H, 1'b1, 32'h0, 5'd7, 1'b1);
        check("lh_ready_req", 32'(ex_ready), 32'h0);
        mem_grant(1);
        check("lh_ready_wait", 32'(ex_ready), 32'h0);
        exp_q.push_back('{K_LD, 32'h80011234, 5'd7, 1'b1, 4'b1100, 1'b1, -1});
        mem_return(32'h80011234, 1);
        check("lh_ready_done", 32'(ex_ready), 32'h1);

        // Misaligned SW, then an ALU op accepted on the very next cycle
        idle(1);
        req_cycles = 0;
        send(32'h3001, 1'b0, 1'b1, SZ_W, 1'b0, 32'hFFFF0000, 5'd0, 1'b0);
        exp_q.push_back('{K_MIS, 32'h0, 5'd0, 1'b0, 4'h0, 1'b0, acc_cyc});
        a0 = acc_cyc;
        send(32'h33, 1'b0, 1'b0, SZ_W, 1'b0, 32'h0, 5'd8, 1'b0);
        exp_q.push_back('{K_ALU, 32'h33, 5'd8, 1'b0, 4'h0, 1'b0, acc_cyc});
        check("mis_next_accept", 32'(acc_cyc - a0), 32'h1);
        idle(2);
        check("mis_no_req", 32'(req_cycles), 32'h0);
        check("rd_hold", 32'(lsu_rd), 32'h8);
        check("rstrb_hold", 32'(lsu_rstrb), 32'hC);
        check("lsign_hold", 32'(lsu_lsign), 32'h1);

        // Aligned stores of each size
        req_q.push_back('{32'h5000, 1'b1, 1'b1, 32'hABCDABCD, 4'b1100});
        send(32'h5002, 1'b0, 1'b1, SZ_H, 1'b0, 32'h1234ABCD, 5'd0, 1'b0);
        mem_grant(0);
        req_q.push_back('{32'h6000, 1'b1, 1'b1, 32'hDEADBEEF, 4'b1111});
        send(32'h6000, 1'b0, 1'b1, SZ_W, 1'b0, 32'hDEADBEEF, 5'd0, 1'b0);
        mem_grant(1);
        req_q.push_back('{32'h9000, 1'b1, 1'b1, 32'h5A5A5A5A, 4'b0100});
        send(32'h9002, 1'b0, 1'b1, SZ_B, 1'b0, 32'h0000005A, 5'd0, 1'b0);
        mem_grant(0);

        // Unsigned LB at offset 1, and LW with lsign requested
        req_q.push_back('{32'h7000, 1'b0, 1'b0, 32'h0, 4'b0000});
        send(32'h7001, 1'b1, 1'b0, SZ_B, 1'b0, 32'h0, 5'd9, 1'b1);
        mem_grant(0);
        exp_q.push_back('{K_LD, 32'h11223344, 5'd9, 1'b1, 4'b0010, 1'b0, -1});
        mem_return(32'h11223344, 2);
        req_q.push_back('{32'h7FFC, 1'b0, 1'b0, 32'h0, 4'b0000});
        send(32'h7FFC, 1'b1, 1'b0, SZ_W, 1'b1, 32'h0, 5'd10, 1'b1);
        mem_grant(3);
        exp_q.push_back('{K_LD, 32'hCAFEF00D, 5'd10, 1'b1, 4'b1111, 1'b0, -1});
        mem_return(32'hCAFEF00D, 0);

        // Misaligned half load and half store
        send(32'h8003, 1'b1, 1'b0, SZ_H, 1'b1, 32'h0, 5'd12, 1'b1);
        exp_q.push_back('{K_MIS, 32'h0, 5'd0, 1'b0, 4'h0, 1'b0, acc_cyc});
        send(32'h8005, 1'b0, 1'b1, SZ_H, 1'b0, 32'h0, 5'd0, 1'b0);
        exp_q.push_back('{K_MIS, 32'h0, 5'd0, 1'b0, 4'h0, 1'b0, acc_cyc});

        // Stray rvld while IDLE
        idle(2);
        s = ld_seen;
        mem_rvld = 1'b1;
        mem_rdata = 32'h5555AAAA;
        @(posedge CLK); #1;
        mem_rvld = 1'b0;
        mem_rdata = '0;
        idle(2);
        check("stray_rvld", 32'(ld_seen), 32'(s));

        // Reset while waiting for load data; late rvld must be dropped
        req_q.push_back('{32'h4000, 1'b0, 1'b0, 32'h0, 4'b0000});
        send(32'h4000, 1'b1, 1'b0, SZ_W, 1'b0, 32'h0, 5'd11, 1'b1);
        mem_grant(0);
        check("wait_ready", 32'(ex_ready), 32'h0);
        #1;
        RSTN = 1'b0;
        #1;
        rst_checks();
        idle(1);
        s = ld_seen;
        RSTN = 1'b1;
        mem_rvld = 1'b1;
        mem_rdata = 32'h77777777;
        @(posedge CLK); #1;
        mem_rvld = 1'b0;
        mem_rdata = '0;
        check("ready_after_midrst", 32'(ex_ready), 32'h1);
        idle(2);
        check("late_rvld", 32'(ld_seen), 32'(s));
        send(32'h44, 1'b0, 1'b0, SZ_W, 1'b0, 32'h0, 5'd13, 1'b1);
        exp_q.push_back('{K_ALU, 32'h44, 5'd13, 1'b1, 4'h0, 1'b0, acc_cyc});

        idle(3);
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        check("req_q_drained", 32'(req_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
